uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester streams and transmitter handshake of the shared UART arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 grant_active;
  logic [IDX_W-1:0]     grant_id;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_active, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_active, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one 8N1 byte transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int BURST_W   = $clog2(MAX_BURST + 2);
  localparam int HOLD_W    = $clog2(HOLD_TIMEOUT + 2);
  localparam int HOLD_LAST = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, grant_id, sel_id, rr_next;
  logic               sel_found;
  logic               grant_active, last_q, hi_cnt;
  logic [7:0]         tx_data;
  logic [BURST_W-1:0] burst_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               granted_valid, xfer, do_grant, do_release, hold_expired, burst_full;
  logic [7:0]         granted_byte;

  assign granted_valid = bus.req_valid[grant_id];
  assign granted_byte  = bus.req_data[8*grant_id +: 8];
  assign rr_next       = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign hold_expired  = (HOLD_TIMEOUT != 0) && (hold_cnt == HOLD_W'(HOLD_LAST));
  assign burst_full    = (MAX_BURST != 0) && (burst_cnt == BURST_W'(MAX_BURST));

  // Scan downwards so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    int j;
    j         = 0;
    sel_id    = rr_ptr;
    sel_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % NUM_REQ;
      if (bus.req_valid[j]) begin
        sel_id    = IDX_W'(j);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d       = state;
    bus.req_ready = '0;
    xfer          = 1'b0;
    do_grant      = 1'b0;
    do_release    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.tx_busy && sel_found) begin
          do_grant = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        bus.req_ready[grant_id] = granted_valid & ~bus.tx_busy;
        if (granted_valid && !bus.tx_busy) begin
          xfer    = 1'b1;
          state_d = SEND;
        end else if (hold_expired) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end
      end
      SEND:    state_d = WAIT_HI;
      // A transmitter that never raises busy still lets us move on after two cycles.
      WAIT_HI: if (bus.tx_busy || hi_cnt) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (last_q || burst_full) begin
            do_release = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      tx_data      <= '0;
      last_q       <= 1'b0;
      burst_cnt    <= '0;
      hold_cnt     <= '0;
      hi_cnt       <= 1'b0;
    end else begin
      if (do_grant) begin
        grant_id     <= sel_id;
        grant_active <= 1'b1;
        burst_cnt    <= '0;
        hold_cnt     <= '0;
      end
      if (xfer) begin
        tx_data   <= granted_byte;
        last_q    <= bus.req_last[grant_id];
        burst_cnt <= burst_cnt + 1'b1;
        hold_cnt  <= '0;
      end else if (state == LOAD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == SEND)         hi_cnt <= 1'b0;
      else if (state == WAIT_HI) hi_cnt <= 1'b1;
      if (do_release) begin
        rr_ptr       <= rr_next;
        grant_active <= 1'b0;
      end
    end
  end

  assign bus.tx_start     = (state == SEND);
  assign bus.tx_data      = tx_data;
  assign bus.grant_active = grant_active;
  assign bus.grant_id     = grant_id;
endmodule
